uart_rx_param: RTL and testbench

UART_RX_PARAM -- requirements
Module: uart_rx_param

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_rx_fifo.sv | 65 ++++++
 rtl/uart_rx_param.sv | 156 +++++++++++++++
 tb/tb_uart_rx_param.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver FSM state encoding, parity modes
// and a 3-sample majority helper.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  function automatic logic maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous frame buffer. Ports: push/push_data in,
// pop/pop_data/valid out, overrun = 1-cycle pulse on a dropped push.
module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             valid,
  output logic             overrun
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             full;
  logic             empty;
  logic             push_en;
  logic             pop_en;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop_en  = pop && !empty;
  // a full buffer still accepts a frame when the head leaves the same cycle
  assign push_en = push && (!full || pop_en);

  assign valid    = !empty;
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_en) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= push && !push_en;
      if (push_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push_en, pop_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampling UART receiver with parity/stop checks
// and a frame FIFO. Ports: rx_inp in; data_out/valid/ready; error flags.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_MODE  = 1,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_inp,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 stop_error,
  output logic                 parity_error,
  output logic                 overrun_error
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int FW = DATA_BITS + 2;

  localparam logic [CW-1:0] MID  = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BLST = BW'(DATA_BITS - 1);
  localparam logic          SLST = 1'(STOP_BITS - 1);

  rx_state_e            state;
  logic [1:0]           sync_q;
  logic [1:0]           hist;
  logic                 rx_s;
  logic                 vote;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 stop_err;
  logic                 par_err;
  logic                 push;
  logic [FW-1:0]        push_frame;
  logic [FW-1:0]        pop_frame;

  assign rx_s = sync_q[1];
  // hist[0] is the previous synchronised sample, hist[1] the one before;
  // evaluating one cycle late centres the vote on hist[0]
  assign vote = maj3(hist[1], hist[0], rx_s);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 2'b11;
      hist   <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx_inp};
      hist   <= {hist[0], rx_s};
    end
  end

  // frame leaves on the final stop-bit vote, not at end of bit
  assign push = (state == STOP) && (cnt == LAST) && (stop_idx == SLST);
  assign push_frame = {shift, stop_err | ~vote, par_err};

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shift    <= '0;
      stop_err <= 1'b0;
      par_err  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          // needs a real 1->0 edge, so a held break never re-triggers
          if (hist[0] && !rx_s) begin
            state    <= START;
            cnt      <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            stop_err <= 1'b0;
            par_err  <= 1'b0;
          end
        end
        START: begin
          if (cnt == MID) begin
            cnt   <= '0;
            state <= vote ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            shift <= {vote, shift[DATA_BITS-1:1]};
            if (bit_idx == BLST) begin
              state <= (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PARITY: begin
          if (cnt == LAST) begin
            cnt     <= '0;
            par_err <= ((^shift) ^ vote) != (PARITY_MODE == PARITY_ODD);
            state   <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == LAST) begin
            cnt <= '0;
            if (!vote) begin
              stop_err <= 1'b1;
            end
            if (stop_idx == SLST) begin
              state <= IDLE;
            end else begin
              stop_idx <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  uart_rx_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_frame),
    .pop       (data_ready),
    .pop_data  (pop_frame),
    .valid     (data_valid),
    .overrun   (overrun_error)
  );

  assign data_out     = pop_frame[FW-1:2];
  assign stop_error   = pop_frame[1];
  assign parity_error = pop_frame[0];

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed + random frames against a serial-line
// model; default instance plus a 7-bit odd-parity 2-stop instance.
module tb_uart_rx_param;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_a = 1'b1;
  logic       rx_b = 1'b1;
  logic       rdy_a = 1'b0;
  logic       rdy_b = 1'b0;
  logic [7:0] dout_a;
  logic [6:0] dout_b;
  logic       dv_a, se_a, pe_a, ov_a;
  logic       dv_b, se_b, pe_b, ov_b;

  int checks = 0;
  int errors = 0;
  int ovr_a = 0;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ov_a) ovr_a <= ovr_a + 1;
  end

  uart_rx_param u_dut_a (
    .clk           (clk),
    .reset         (reset),
    .rx_inp        (rx_a),
    .data_out      (dout_a),
    .data_valid    (dv_a),
    .data_ready    (rdy_a),
    .stop_error    (se_a),
    .parity_error  (pe_a),
    .overrun_error (ov_a)
  );

  uart_rx_param #(
    .DATA_BITS    (7),
    .CLKS_PER_BIT (CPB),
    .PARITY_MODE  (2),
    .STOP_BITS    (2),
    .FIFO_DEPTH   (4)
  ) u_dut_b (
    .clk           (clk),
    .reset         (reset),
    .rx_inp        (rx_b),
    .data_out      (dout_b),
    .data_valid    (dv_b),
    .data_ready    (rdy_b),
    .stop_error    (se_b),
    .parity_error  (pe_b),
    .overrun_error (ov_b)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // serial line model: start, data LSB first, optional parity, stops
  task automatic send(input bit sel, input logic [8:0] data,
                      input int nb, input int pmode, input bit pflip,
                      input logic [1:0] stops, input int nstop,
                      input int limit);
    logic q[$];
    logic p;
    p = 1'b0;
    q.push_back(1'b0);
    for (int i = 0; i < nb; i++) begin
      q.push_back(data[i]);
      p = p ^ data[i];
    end
    if (pmode != 0) begin
      if (pmode == 2) p = ~p;
      q.push_back(p ^ pflip);
    end
    for (int s = 0; s < nstop; s++) q.push_back(stops[s]);
    for (int i = 0; i < q.size() && i < limit; i++) begin
      if (sel) rx_b = q[i];
      else rx_a = q[i];
      repeat (CPB) @(negedge clk);
    end
    if (sel) rx_b = 1'b1;
    else rx_a = 1'b1;
  endtask

  task automatic expect_frame(input bit sel, input string tag,
                              input logic [8:0] ed, input logic ese,
                              input logic epe);
    bit ok;
    logic [8:0] d;
    logic se, pe;
    ok = 1'b0;
    d = '0;
    se = 1'b0;
    pe = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (sel ? dv_b : dv_a) ok = 1'b1;
    end
    check({tag, "_valid"}, {31'd0, ok}, 32'd1);
    if (ok) begin
      d  = sel ? {2'b0, dout_b} : {1'b0, dout_a};
      se = sel ? se_b : se_a;
      pe = sel ? pe_b : pe_a;
      check({tag, "_data"}, {23'd0, d}, {23'd0, ed});
      check({tag, "_stop"}, {31'd0, se}, {31'd0, ese});
      check({tag, "_par"}, {31'd0, pe}, {31'd0, epe});
      if (sel) rdy_b = 1'b1;
      else rdy_a = 1'b1;
      @(negedge clk);
      rdy_a = 1'b0;
      rdy_b = 1'b0;
    end
  endtask

  initial begin
    logic [8:0] d;
    bit flip;
    bit bad;
    int base;
    logic [7:0] exp_q[$];

    reset = 1'b1;
    idle(4);
    check("rst_valid", {31'd0, dv_a}, 32'd0);
    check("rst_data", {24'd0, dout_a}, 32'd0);
    check("rst_stop", {31'd0, se_a}, 32'd0);
    check("rst_par", {31'd0, pe_a}, 32'd0);
    check("rst_ovr", {31'd0, ov_a}, 32'd0);
    check("rst_valid_b", {31'd0, dv_b}, 32'd0);
    reset = 1'b0;
    idle(5);

    send(0, 9'h35, 8, 1, 0, 2'b01, 1, 99);
    expect_frame(0, "f35", 9'h35, 0, 0);
    idle(4);

    send(0, 9'hA5, 8, 1, 1, 2'b01, 1, 99);
    expect_frame(0, "fA5_perr", 9'hA5, 0, 1);
    idle(4);

    d = 9'($urandom_range(0, 255));
    send(0, d, 8, 1, 0, 2'b00, 1, 99);
    expect_frame(0, "stop0", d, 1, 0);
    idle(4);

    rx_a = 1'b0;
    idle(4);
    rx_a = 1'b1;
    idle(3 * CPB);
    check("glitch_none", {31'd0, dv_a}, 32'd0);
    d = 9'($urandom_range(0, 255));
    send(0, d, 8, 1, 0, 2'b01, 1, 99);
    expect_frame(0, "post_glitch", d, 0, 0);
    idle(4);

    for (int k = 0; k < 6; k++) begin
      d = 9'($urandom_range(0, 255));
      flip = 1'($urandom_range(0, 1));
      bad = 1'($urandom_range(0, 1));
      send(0, d, 8, 1, flip, {1'b1, ~bad}, 1, 99);
      idle($urandom_range(2, 20));
      expect_frame(0, "rand", d, bad, flip);
      idle(3);
    end

    base = ovr_a;
    for (int k = 0; k < 5; k++) begin
      d = 9'($urandom_range(0, 255));
      send(0, d, 8, 1, 0, 2'b01, 1, 99);
      if (exp_q.size() < 4) exp_q.push_back(d[7:0]);
      idle(4);
    end
    check("ovr_pulses", ovr_a - base, 32'd1);
    while (exp_q.size() > 0) begin
      d = {1'b0, exp_q.pop_front()};
      expect_frame(0, "drain", d, 0, 0);
    end
    idle(2);
    check("drain_empty", {31'd0, dv_a}, 32'd0);

    send(0, 9'hC3, 8, 1, 0, 2'b01, 1, 4);
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    idle(20);
    check("rst_mid_none", {31'd0, dv_a}, 32'd0);
    send(0, 9'h5A, 8, 1, 0, 2'b01, 1, 99);
    expect_frame(0, "f5A", 9'h5A, 0, 0);
    idle(2 * CPB);
    check("f5A_only", {31'd0, dv_a}, 32'd0);

    rx_a = 1'b0;
    idle(12 * CPB);
    expect_frame(0, "break", 9'h000, 1, 0);
    idle(4 * CPB);
    check("break_once", {31'd0, dv_a}, 32'd0);
    rx_a = 1'b1;
    idle(2 * CPB);
    d = 9'($urandom_range(0, 255));
    send(0, d, 8, 1, 0, 2'b01, 1, 99);
    expect_frame(0, "post_break", d, 0, 0);

    d = 9'($urandom_range(0, 127));
    send(1, d, 7, 2, 0, 2'b01, 2, 99);
    expect_frame(1, "b7_stop2", d, 1, 0);
    idle(4);
    d = 9'($urandom_range(0, 127));
    send(1, d, 7, 2, 0, 2'b11, 2, 99);
    expect_frame(1, "b7_clean", d, 0, 0);
    idle(4);
    d = 9'($urandom_range(0, 127));
    send(1, d, 7, 2, 1, 2'b11, 2, 99);
    expect_frame(1, "b7_perr", d, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
